// File: rtl/mul_arbiter.sv
// Sequencing front-end that lets two requesters share one Booth multiplier.
// It arbitrates round-robin, runs one multiply at a time and aborts a stuck multiply with a watchdog.
module mul_arbiter #(
    parameter int SIZE    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [SIZE-1:0]     a0,
    input  logic [SIZE-1:0]     b0,
    input  logic [SIZE-1:0]     a1,
    input  logic [SIZE-1:0]     b1,
    output logic                done0,
    output logic                done1,
    output logic                err,
    output logic [2*SIZE-1:0]   result,
    output logic                busy,
    output logic                owner,
    output logic [SIZE-1:0]     mul_a,
    output logic [SIZE-1:0]     mul_b,
    output logic                mul_start,
    input  logic [2*SIZE-1:0]   mul_result,
    input  logic                mul_fin
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic [CNT_W-1:0]    count_inc;
    logic [SIZE-1:0]     mul_a_next;
    logic [SIZE-1:0]     mul_b_next;
    logic                owner_next;
    logic                err_next;
    logic [2*SIZE-1:0]   result_next;
    logic                grant0;
    logic                grant1;

    // On a tie the requester that did not win last time gets the grant.
    assign grant0    = req0 && (!req1 || owner);
    assign grant1    = req1 && !grant0;
    assign count_inc = count + CNT_W'(1);

    always_comb begin
        state_next  = state;
        count_next  = count;
        mul_a_next  = mul_a;
        mul_b_next  = mul_b;
        owner_next  = owner;
        err_next    = err;
        result_next = result;

        case (state)
            IDLE: begin
                if (grant0) begin
                    mul_a_next = a0;
                    mul_b_next = b0;
                    owner_next = 1'b0;
                    state_next = START;
                end else if (grant1) begin
                    mul_a_next = a1;
                    mul_b_next = b1;
                    owner_next = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                count_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // A completion in the last allowed cycle still counts as success.
                if (mul_fin) begin
                    result_next = mul_result;
                    err_next    = 1'b0;
                    state_next  = DONE;
                end else if (count_inc == TIMEOUT_CNT) begin
                    result_next = '0;
                    err_next    = 1'b1;
                    count_next  = count_inc;
                    state_next  = DONE;
                end else begin
                    count_next = count_inc;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            owner  <= 1'b1;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            mul_a  <= mul_a_next;
            mul_b  <= mul_b_next;
            owner  <= owner_next;
            err    <= err_next;
            result <= result_next;
        end
    end

    assign mul_start = (state == START);
    assign busy      = (state != IDLE);
    assign done0     = (state == DONE) && !owner;
    assign done1     = (state == DONE) && owner;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized operations
// compared against a cycle-level reference model of arbitration, latency and product.
module tb_mul_arbiter;

    localparam int SIZE    = 4;
    localparam int TIMEOUT = 16;
    localparam int PW      = 2 * SIZE;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [SIZE-1:0]   a0, b0, a1, b1;
    logic              done0, done1, err;
    logic [PW-1:0]     result;
    logic              busy, owner;
    logic [SIZE-1:0]   mul_a, mul_b;
    logic              mul_start;
    logic [PW-1:0]     mul_result;
    logic              mul_fin;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit            model_owner = 1'b1;
    logic [PW-1:0] last_result = '0;

    mul_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .done0      (done0),
        .done1      (done1),
        .err        (err),
        .result     (result),
        .busy       (busy),
        .owner      (owner),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .mul_fin    (mul_fin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: mul_fin rises mul_delay+1 cycles after the start cycle and stays high.
    int            mul_delay = 6;
    bit            mul_never = 1'b0;
    int            mul_cnt   = 0;
    logic          fin_q     = 1'b0;
    logic          fin_force = 1'b0;
    logic [PW-1:0] prod_q    = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            fin_q   <= 1'b0;
            mul_cnt <= mul_delay;
            prod_q  <= PW'($signed({{SIZE{mul_a[SIZE-1]}}, mul_a}) * $signed({{SIZE{mul_b[SIZE-1]}}, mul_b}));
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1 && !mul_never) fin_q <= 1'b1;
        end
    end

    assign mul_fin    = fin_q | fin_force;
    assign mul_result = prod_q;

    function automatic logic [PW-1:0] ref_product(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int sa, sb;
        sa = a[SIZE-1] ? int'(a) - (1 << SIZE) : int'(a);
        sb = b[SIZE-1] ? int'(b) - (1 << SIZE) : int'(b);
        return PW'(sa * sb);
    endfunction

    // Cycles from the granting IDLE cycle to the done pulse; completion is first seen in cycle delay+2.
    function automatic int ref_latency(input int delay, input bit never);
        if (never || (delay + 2 > TIMEOUT + 1)) return TIMEOUT + 2;
        return delay + 3;
    endfunction

    function automatic bit ref_winner(input bit r0, input bit r1);
        if (r0 && r1) return !model_owner;
        return r0 ? 1'b0 : 1'b1;
    endfunction

    task automatic wait_done(input int limit, output int at, output logic d0, output logic d1,
                             output logic e, output logic [PW-1:0] r, output bit timed_out);
        timed_out = 1'b1;
        at = -1; d0 = 1'b0; d1 = 1'b0; e = 1'b0; r = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                at = cyc; d0 = done0; d1 = done1; e = err; r = result;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({done0, done1, err, result, busy, mul_a, mul_b, mul_start} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {done0, done1, err, result, busy, mul_a, mul_b, mul_start});
        end
        checks++;
        if (owner !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_owner: got %b expected 1", owner);
        end
        reset = 1'b1;
        model_owner = 1'b1;
        last_result = '0;
    endtask

    task automatic test_single();
        int t0, at;
        logic d0, d1, e;
        logic [PW-1:0] r;
        bit to;
        mul_delay = 6;
        @(negedge clk);
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        t0 = cyc;
        @(negedge clk);
        checks++;
        if ({mul_start, owner, busy} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL single_start: got start/owner/busy=%b expected 101", {mul_start, owner, busy});
        end
        a0 = 4'd7; req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({mul_start, mul_a} !== {1'b0, 4'd3}) begin
            errors++;
            $display("[TB] FAIL operand_stability: got start=%b mul_a=%h expected start=0 mul_a=3", mul_start, mul_a);
        end
        wait_done(40, at, d0, d1, e, r, to);
        checks++;
        if (to || (at - t0) != 9 || d0 !== 1'b1 || d1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done: got timeout=%0d cycle=%0d d0=%b d1=%b expected cycle=9 d0=1 d1=0",
                     to, at - t0, d0, d1);
        end
        checks++;
        if ({e, r} !== {1'b0, 8'h0F}) begin
            errors++;
            $display("[TB] FAIL single_result: got err=%b result=%h expected err=0 result=0f", e, r);
        end
        @(negedge clk);
        checks++;
        if ({busy, done0, done1} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_after: got busy/done0/done1=%b expected 000", {busy, done0, done1});
        end
        model_owner = 1'b0;
        last_result = 8'h0F;
    endtask

    task automatic test_signed();
        int t0, at;
        logic d0, d1, e;
        logic [PW-1:0] r;
        bit to;
        req1 = 1'b1; a1 = 4'hD; b1 = 4'h5;
        t0 = cyc;
        @(negedge clk);
        req1 = 1'b0; a1 = 4'h0;
        wait_done(40, at, d0, d1, e, r, to);
        checks++;
        if (to || (at - t0) != 9 || {d0, d1, e, r} !== {1'b0, 1'b1, 1'b0, 8'hF1}) begin
            errors++;
            $display("[TB] FAIL signed_done: got timeout=%0d cycle=%0d d0=%b d1=%b err=%b result=%h expected cycle=9 d1=1 err=0 result=f1",
                     to, at - t0, d0, d1, e, r);
        end
        model_owner = 1'b1;
        last_result = 8'hF1;
        @(negedge clk);
    endtask

    task automatic test_tie();
        int t_prev, at;
        logic d0, d1, e;
        logic [PW-1:0] r;
        bit to, w;
        logic [PW-1:0] exp_r;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_owner = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 4'd2; b0 = 4'd3; a1 = 4'hF; b1 = 4'hF;
        t_prev = cyc;
        for (int k = 0; k < 4; k++) begin
            w = ref_winner(1'b1, 1'b1);
            exp_r = w ? ref_product(4'hF, 4'hF) : ref_product(4'd2, 4'd3);
            wait_done(40, at, d0, d1, e, r, to);
            checks++;
            if (to || (at - t_prev) != 9 || {d0, d1} !== {!w, w} || {e, r} !== {1'b0, exp_r}) begin
                errors++;
                $display("[TB] FAIL tie_op%0d: got timeout=%0d cycle=%0d d0=%b d1=%b err=%b result=%h expected cycle=9 owner=%0d err=0 result=%h",
                         k, to, at - t_prev, d0, d1, e, r, w, exp_r);
            end
            model_owner = w;
            last_result = exp_r;
            t_prev = at + 1;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int t0, at;
        logic d0, d1, e;
        logic [PW-1:0] r;
        bit to, seen;
        logic [SIZE-1:0] na, nb;
        mul_delay = 6;
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd2;
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fin_force = 1'b1;
        checks++;
        if ({done0, done1, err, result, busy, mul_a, mul_b, mul_start} !== '0 || owner !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midwait_reset: got outputs=%h owner=%b expected outputs=0 owner=1",
                     {done0, done1, err, result, busy, mul_a, mul_b, mul_start}, owner);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done0 || done1 || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL midwait_no_done: got done/busy activity=1 expected 0");
        end
        fin_force = 1'b0;
        model_owner = 1'b1;
        na = SIZE'($urandom_range(0, 15));
        nb = SIZE'($urandom_range(0, 15));
        req0 = 1'b1; a0 = na; b0 = nb;
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(40, at, d0, d1, e, r, to);
        checks++;
        if (to || (at - t0) != 9 || {d0, d1, e} !== 3'b100 || r !== ref_product(na, nb)) begin
            errors++;
            $display("[TB] FAIL midwait_recover: got timeout=%0d cycle=%0d d0=%b d1=%b err=%b result=%h expected cycle=9 d0=1 err=0 result=%h",
                     to, at - t0, d0, d1, e, r, ref_product(na, nb));
        end
        model_owner = 1'b0;
        last_result = ref_product(na, nb);
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        int t0, at;
        logic d0, d1, e;
        logic [PW-1:0] r;
        bit to;
        mul_never = 1'b1;
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, result} !== {1'b1, last_result}) begin
            errors++;
            $display("[TB] FAIL watchdog_hold: got busy=%b result=%h expected busy=1 result=%h", busy, result, last_result);
        end
        wait_done(40, at, d0, d1, e, r, to);
        checks++;
        if (to || (at - t0) != TIMEOUT + 2 || {d0, d1, e, r} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL watchdog_abort: got timeout=%0d cycle=%0d d0=%b d1=%b err=%b result=%h expected cycle=%0d d0=1 err=1 result=00",
                     to, at - t0, d0, d1, e, r, TIMEOUT + 2);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL watchdog_busy: got %b expected 0", busy);
        end
        mul_never = 1'b0;
        model_owner = 1'b0;
        last_result = '0;
    endtask

    task automatic test_random();
        int t0, at, pat, lat;
        logic d0, d1, e;
        logic [PW-1:0] r, exp_r;
        bit to, w, exp_err;
        logic [SIZE-1:0] ra0, rb0, ra1, rb1;
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_idle%0d: got busy=%b expected 0", k, busy);
            end
            pat = $urandom_range(1, 3);
            mul_delay = $urandom_range(1, TIMEOUT + 2);
            ra0 = SIZE'($urandom); rb0 = SIZE'($urandom);
            ra1 = SIZE'($urandom); rb1 = SIZE'($urandom);
            req0 = pat[0]; req1 = pat[1];
            a0 = ra0; b0 = rb0; a1 = ra1; b1 = rb1;
            w = ref_winner(pat[0], pat[1]);
            lat = ref_latency(mul_delay, 1'b0);
            exp_err = (lat == TIMEOUT + 2) && (mul_delay + 2 > TIMEOUT + 1);
            exp_r = exp_err ? '0 : (w ? ref_product(ra1, rb1) : ref_product(ra0, rb0));
            t0 = cyc;
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b0;
            a0 = SIZE'($urandom); b0 = SIZE'($urandom);
            a1 = SIZE'($urandom); b1 = SIZE'($urandom);
            wait_done(40, at, d0, d1, e, r, to);
            checks++;
            if (to || (at - t0) != lat || {d0, d1} !== {!w, w} || {e, r} !== {exp_err, exp_r}) begin
                errors++;
                $display("[TB] FAIL rand_op%0d: got timeout=%0d cycle=%0d d0=%b d1=%b err=%b result=%h expected cycle=%0d owner=%0d err=%b result=%h",
                         k, to, at - t0, d0, d1, e, r, lat, w, exp_err, exp_r);
            end
            model_owner = w;
            last_result = exp_r;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_signed();
        test_tie();
        test_reset_mid_wait();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Sequencing and arbitration front-end for the shared Booth multiplier (`multiplicador`). Two requesters share one multiplier instance: the block arbitrates round-robin, captures the winner's operands, pulses the multiplier start, waits for its `Fin`, and returns the signed product with a per-requester done pulse. A watchdog aborts an operation whose `Fin` never arrives.

## Interface

Parameters:
- `SIZE`, 4: operand width in bits. Product width is 2*SIZE.
- `TIMEOUT`, 16: maximum WAIT cycles before abort. Must be ≥ 1. Counter width is clog2(TIMEOUT+1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req0`, `req1`  in  1  level request from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1`  in  SIZE  operands (multiplicand, multiplier), two's complement. Sampled on grant only.
- `done0`, `done1`  out  1  one-cycle pulse: operation for requester 0 / 1 finished.
- `err`  out  1  qualifies the current done pulse: 1 means watchdog abort.
- `result`  out  2*SIZE  product register; valid while a done pulse is high; held until the next completion.
- `busy`  out  1  high in START, WAIT and DONE.
- `owner`  out  1  index of the current or last granted requester.
- `mul_a`, `mul_b`  out  SIZE  operands to the multiplier; held stable from START until the block leaves WAIT.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_result`  in  2*SIZE  multiplier product.
- `mul_fin`  in  1  multiplier completion (level).

## Operation

- States: IDLE, START, WAIT, DONE.
- IDLE: samples `req0`/`req1`.
  - If only one is high, grant it.
  - If both are high, grant the requester that is not `owner` (round-robin; `owner` resets to 1, so requester 0 wins the first tie).
  - On grant: latch the selected a/b into `mul_a`/`mul_b`, set `owner`, go to START.
  - With no request, stay in IDLE.
- START: `mul_start`=1 for exactly this cycle. Clear the watchdog counter. `mul_fin` is ignored in this state. Next state is WAIT.
- WAIT: the counter increments each cycle.
  - `mul_fin`=1: capture `mul_result` into `result`, set `err`=0, go to DONE.
  - Counter reaches TIMEOUT with `mul_fin` still low: set `result`=0 and `err`=1, go to DONE.
  - If `mul_fin` is high in the same cycle the counter reaches TIMEOUT, `mul_fin` wins (`err`=0).
- DONE: `done<owner>`=1 for one cycle, then return to IDLE. Requests are not sampled in DONE.
- Requester rule: `req` must be low in the cycle after its done pulse. A `req` still high in that IDLE cycle is treated as a new request.
- Operands are never re-sampled during an operation. Changes on a0/b0/a1/b1 after grant have no effect.
- Arithmetic: the block does not modify the product. `result` is a bit copy of `mul_result` (signed 2*SIZE).

## Timing

- Reset (`reset`=0 at a rising edge) forces IDLE and clears the counter. Every output resets to 0: `done0`, `done1`, `err`, `result`, `busy`, `mul_a`, `mul_b`, `mul_start`. The exception is `owner`, which resets to 1.
- Reset is honored in any state, including mid-operation. There is no done pulse for an aborted operation, and the next grant starts cleanly.
- Latency, with `req` high in IDLE at cycle 0:
  - START in cycle 1.
  - WAIT from cycle 2.
  - If `mul_fin` is first seen in WAIT cycle 2+k, DONE (done pulse) follows in cycle 3+k.
  - Minimum request-to-done is 3 cycles.
- Back-to-back: with both `req` held, grants alternate 0,1,0,1. Each operation is followed by one IDLE cycle.
- `busy` is 0 only in IDLE.

## Test plan

- Reset mid-WAIT: `reset`=0 for one cycle during WAIT, then `mul_fin`=1.
  - Required: all outputs 0, `owner`=1, no done pulse, block in IDLE.
  - A new `req0` then completes normally.
- Single request: SIZE=4, behavioral multiplier asserting `mul_fin` 6 cycles after `mul_start`. `req0`, a0=3, b0=5.
  - Required: `mul_start` in cycle 1, `done0` in cycle 9, `result`=8'h0F, `err`=0, `done1` never high.
- Signed operands: `req1`, a1=4'hD (−3), b1=4'h5.
  - Required: `done1` with `result`=8'hF1 (−15).
- Tie and round-robin: `req0` and `req1` high together from reset, with a0=2, b0=3, a1=4'hF, b1=4'hF.
  - Required: first `done0` with 8'h06, then `done1` with 8'h01, alternating while both stay high.
- Operand stability: change a0 to 7 in the cycle after grant.
  - Required: `mul_a` stays 3 and `result`=8'h0F.
- Watchdog: TIMEOUT=16, multiplier never asserts `mul_fin`.
  - Required: `done0` with `err`=1 and `result`=0, exactly 16 WAIT cycles after START. `busy` drops the cycle after the done pulse.
